fu_issue_arbiter: RTL and testbench

FU_ISSUE_ARBITER -- requirements
Module: fu_issue_arbiter

---
 rtl/fu_issue_arbiter.sv | 104 ++++++++++
 tb/tb_fu_issue_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fu_issue_arbiter.sv
// Round-robin issue arbiter feeding one shared fixed-latency functional unit.
// Optional perf counters (grant_cnt/stall_cnt) enabled by FU_ISSUE_ARB_PERF_CNT_EN.
module fu_issue_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 4,
    parameter int LAT     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    input  logic                     flush,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     fu_start,
    output logic [TAG_W-1:0]         fu_tag,
    output logic                     fu_done,
    output logic                     busy
`ifdef FU_ISSUE_ARB_PERF_CNT_EN
    ,
    output logic [15:0]              grant_cnt,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [3:0]       lat_cnt;
    logic [IDX_W-1:0] last_winner;
    logic [IDX_W-1:0] win;
    logic             found;
    logic             arb_ok;
    logic             do_grant;

    // Search order starts just past the previous winner and wraps.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            logic [IDX_W-1:0] cand;
            cand = IDX_W'((32'(last_winner) + 1 + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign arb_ok   = (state == IDLE) || (lat_cnt == 4'd0 && !flush);
    assign do_grant = arb_ok && found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            last_winner <= IDX_W'(NUM_REQ - 1);
            grant       <= '0;
            fu_start    <= 1'b0;
            fu_tag      <= '0;
        end else if (do_grant) begin
            state       <= BUSY;
            lat_cnt     <= 4'(LAT - 1);
            last_winner <= win;
            grant       <= NUM_REQ'(1) << win;
            fu_start    <= 1'b1;
            fu_tag      <= req_tag[win*TAG_W +: TAG_W];
        end else begin
            grant    <= '0;
            fu_start <= 1'b0;
            if (state == BUSY) begin
                if (flush || lat_cnt == 4'd0) begin
                    state   <= IDLE;
                    lat_cnt <= '0;
                end else begin
                    lat_cnt <= lat_cnt - 4'd1;
                end
            end
        end
    end

    assign busy    = (state == BUSY);
    assign fu_done = (state == BUSY) && (lat_cnt == 4'd0) && !flush;

`ifdef FU_ISSUE_ARB_PERF_CNT_EN
    // Counted at the arbitration edge: a stall is a pending request that did not win this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (do_grant && grant_cnt != 16'hFFFF)
                grant_cnt <= grant_cnt + 16'd1;
            if (req != '0 && !do_grant && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Directed bench for fu_issue_arbiter: one LAT=3 instance and one LAT=1 instance.
module tb_fu_issue_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, req1;
    logic [15:0] tag, tag1;
    logic        flush, flush1;
    logic [3:0]  grant, grant1;
    logic        fu_start, fu_start1, fu_done, fu_done1, busy, busy1;
    logic [3:0]  fu_tag, fu_tag1;
`ifdef FU_ISSUE_ARB_PERF_CNT_EN
    logic [15:0] grant_cnt, stall_cnt, grant_cnt1, stall_cnt1;
`endif

    int vecs = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fu_issue_arbiter #(.NUM_REQ(4), .TAG_W(4), .LAT(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_tag(tag), .flush(flush),
        .grant(grant), .fu_start(fu_start), .fu_tag(fu_tag), .fu_done(fu_done),
        .busy(busy)
`ifdef FU_ISSUE_ARB_PERF_CNT_EN
        , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
    );

    fu_issue_arbiter #(.NUM_REQ(4), .TAG_W(4), .LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .req_tag(tag1), .flush(flush1),
        .grant(grant1), .fu_start(fu_start1), .fu_tag(fu_tag1), .fu_done(fu_done1),
        .busy(busy1)
`ifdef FU_ISSUE_ARB_PERF_CNT_EN
        , .grant_cnt(grant_cnt1), .stall_cnt(stall_cnt1)
`endif
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] eg;
        logic       ed;
        rst_n = 1'b0; req = '0; tag = '0; flush = 1'b0;
        req1 = '0; tag1 = '0; flush1 = 1'b0;

        // Reset state
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_fu_tag", 32'(fu_tag), 32'h0);
        check("rst_fu_done", 32'(fu_done), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        tick;                                    // cycle 1

        // Single request, requester 2, tag 9
        req = 4'b0100; tag = 16'h0900;
        check("single_c1_grant", 32'(grant), 32'h0);
        tick;                                    // cycle 2 (G)
        check("single_c2_grant", 32'(grant), 32'h4);
        check("single_c2_start", 32'(fu_start), 32'h1);
        check("single_c2_tag", 32'(fu_tag), 32'h9);
        check("single_c2_busy", 32'(busy), 32'h1);
        check("single_c2_done", 32'(fu_done), 32'h0);
        req = '0;
        tick;                                    // cycle 3
        check("single_c3_start", 32'(fu_start), 32'h0);
        check("single_c3_busy", 32'(busy), 32'h1);
        check("single_c3_done", 32'(fu_done), 32'h0);
        tick;                                    // cycle 4
        check("single_c4_done", 32'(fu_done), 32'h1);
        check("single_c4_busy", 32'(busy), 32'h1);
        tick;                                    // cycle 5
        check("single_c5_busy", 32'(busy), 32'h0);
        check("single_c5_done", 32'(fu_done), 32'h0);
        check("single_c5_tag_hold", 32'(fu_tag), 32'h9);

        // Round-robin with all four requesting
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        tick;                                    // cycle 1
        req = 4'b1111; tag = 16'hDCBA;
        for (int c = 1; c <= 14; c++) begin
            eg = (c >= 2 && (c - 2) % 3 == 0) ? (4'b0001 << (((c - 2) / 3) % 4)) : 4'b0000;
            ed = (c >= 4 && (c - 4) % 3 == 0);
            check($sformatf("rr_grant_c%0d", c), 32'(grant), 32'(eg));
            check($sformatf("rr_done_c%0d", c), 32'(fu_done), 32'(ed));
            check($sformatf("rr_busy_c%0d", c), 32'(busy), (c >= 2) ? 32'h1 : 32'h0);
            if (c < 14) tick;
        end
        check("rr_c14_tag", 32'(fu_tag), 32'hA);
`ifdef FU_ISSUE_ARB_PERF_CNT_EN
        check("perf_grant_cnt", 32'(grant_cnt), 32'd5);
        check("perf_stall_cnt", 32'(stall_cnt), 32'd8);
`endif

        // Flush at G+1 (G = cycle 14, requester 0)
        tick;                                    // cycle 15
        flush = 1'b1; #1;
        check("flush_c15_done", 32'(fu_done), 32'h0);
        check("flush_c15_busy", 32'(busy), 32'h1);
        tick;                                    // cycle 16, flush still high while IDLE
        check("flush_c16_busy", 32'(busy), 32'h0);
        check("flush_c16_grant", 32'(grant), 32'h0);
        check("flush_c16_done", 32'(fu_done), 32'h0);
        tick;                                    // cycle 17
        check("flush_c17_grant", 32'(grant), 32'h2);
        check("flush_c17_tag", 32'(fu_tag), 32'hB);
        flush = 1'b0;
        tick;                                    // cycle 18
        tick;                                    // cycle 19: completion cycle
        check("flush_c19_done_pre", 32'(fu_done), 32'h1);
        flush = 1'b1; #1;
        check("flush_c19_done_supp", 32'(fu_done), 32'h0);
        tick;                                    // cycle 20
        check("flush_c20_busy", 32'(busy), 32'h0);
        check("flush_c20_grant", 32'(grant), 32'h0);
        flush = 1'b0;
        tick;                                    // cycle 21
        check("flush_c21_grant", 32'(grant), 32'h4);
        check("flush_c21_tag", 32'(fu_tag), 32'hC);

        // Asynchronous reset in the middle of a BUSY cycle
        #2 rst_n = 1'b0;
        #1;
        check("arst_grant", 32'(grant), 32'h0);
        check("arst_start", 32'(fu_start), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_done", 32'(fu_done), 32'h0);
        check("arst_tag", 32'(fu_tag), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        tick;                                    // cycle 1 after release
        check("arst_c1_grant", 32'(grant), 32'h1);
        check("arst_c1_tag", 32'(fu_tag), 32'hA);
        check("arst_c1_done", 32'(fu_done), 32'h0);
        tick;
        check("arst_c2_done", 32'(fu_done), 32'h0);
        req = '0;
        tick;
        check("arst_c3_done", 32'(fu_done), 32'h1);

        // LAT=1: requesters 0 and 1 alternate every cycle
        req1 = 4'b0011; tag1 = 16'h0021;
        tick;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("lat1_grant_%0d", k), 32'(grant1), (k % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("lat1_start_%0d", k), 32'(fu_start1), 32'h1);
            check($sformatf("lat1_done_%0d", k), 32'(fu_done1), 32'h1);
            check($sformatf("lat1_tag_%0d", k), 32'(fu_tag1), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick;
        end
        req1 = '0;
        tick;
        check("lat1_idle_busy", 32'(busy1), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
